// File: rtl/opp_dac_arbiter_if.sv
// -----------------------------------------------------------------------------
// opp_dac_arbiter_if
//   Word-issue handshake between the output-channel arbiter and the DAC
//   instruction queue write port.
//
//   dac_data_out  W_DATA  word being issued (arbiter -> queue)
//   dac_chan_out  W_CH    channel index of dac_data_out (arbiter -> queue)
//   dac_req_out   1       issue request, held until acknowledged
//   dac_ack_in    1       queue accepted the word (queue -> arbiter)
//
//   Modports: master = arbiter side, slave = queue side.
// -----------------------------------------------------------------------------
interface opp_dac_arbiter_if #(
  parameter int W_DATA = 16,
  parameter int W_CH   = 3
);
  logic [W_DATA-1:0] dac_data_out;
  logic [W_CH-1:0]   dac_chan_out;
  logic              dac_req_out;
  logic              dac_ack_in;

  modport master (
    output dac_data_out,
    output dac_chan_out,
    output dac_req_out,
    input  dac_ack_in
  );

  modport slave (
    input  dac_data_out,
    input  dac_chan_out,
    input  dac_req_out,
    output dac_ack_in
  );
endinterface

// File: rtl/opp_dac_arbiter.sv
// -----------------------------------------------------------------------------
// opp_dac_arbiter
//   Shares one DAC instruction-queue write port between N_CH output
//   preprocessor channels. Each channel holds one pending word (newest wins);
//   pending channels are granted round-robin and issued over a req/ack
//   handshake, with a one-cycle request-low gap between words.
//
// Ports
//   clk_in         system clock
//   reset_n_in     synchronous reset, active low
//   data_in        packed channel words, ch i = data_in[i*W_DATA +: W_DATA]
//   data_valid_in  per-channel one-cycle valid strobe
//   chan_en_in     per-channel enable; disabled channels are dropped
//   dac_if         issue handshake (data, chan, req out / ack in)
//   busy_out       high whenever the arbiter is not idle
//   overrun_out    sticky per-channel overwrite flag (OPP_ARB_OVERRUN_EN only)
//
// Configuration
//   OPP_ARB_OVERRUN_EN  when defined, adds overrun_out and its tracking logic.
// -----------------------------------------------------------------------------
module opp_dac_arbiter #(
  parameter int N_CH   = 8,
  parameter int W_DATA = 16,
  parameter int W_CH   = 3
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic [N_CH*W_DATA-1:0] data_in,
  input  logic [N_CH-1:0]        data_valid_in,
  input  logic [N_CH-1:0]        chan_en_in,
  opp_dac_arbiter_if.master      dac_if,
  output logic                   busy_out
`ifdef OPP_ARB_OVERRUN_EN
  ,
  output logic [N_CH-1:0]        overrun_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [W_DATA-1:0] r_word [N_CH];
  logic [N_CH-1:0]   r_pending;
  logic [W_CH-1:0]   r_last_grant;
  logic [W_DATA-1:0] r_data;
  logic [W_CH-1:0]   r_chan;
  logic              r_req;
  logic              r_busy;

  logic [N_CH-1:0]   w_req_mask;
  logic              w_found;
  logic [W_CH-1:0]   w_grant_idx;
  logic              w_grant_now;
  logic [N_CH-1:0]   w_grant_vec;
  int                w_scan;

  assign w_req_mask = r_pending & chan_en_in;

  // Round-robin search starting one past the last granted channel, wrapping
  // N_CH-1 -> 0, so the channel just served has the lowest priority.
  // NOTE: every variable written here gets a default first, so no latch is
  // inferred when the search finds nothing.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_scan      = 0;
    for (int k = 1; k <= N_CH; k++) begin
      w_scan = int'(r_last_grant) + k;
      if (w_scan >= N_CH) w_scan = w_scan - N_CH;
      if (!w_found && w_req_mask[w_scan[W_CH-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan[W_CH-1:0];
      end
    end
  end

  assign w_grant_now = (r_state == ST_IDLE) && w_found;
  assign w_grant_vec = w_grant_now ? (N_CH'(1) << w_grant_idx) : '0;

  // Word storage. A strobe on the channel being granted this edge overwrites
  // the slot only after the grant has read the old word.
  // NOTE: the word slots carry no reset; a slot is only ever read when its
  // pending flag (which is reset) says it holds a valid word.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < N_CH; i++) begin
      if (chan_en_in[i] && data_valid_in[i]) r_word[i] <= data_in[i*W_DATA +: W_DATA];
    end
  end

  // Pending flags: disable clears, a new strobe sets (and wins over a grant
  // in the same cycle), a grant clears.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!chan_en_in[i])         r_pending[i] <= 1'b0;
        else if (data_valid_in[i])  r_pending[i] <= 1'b1;
        else if (w_grant_vec[i])    r_pending[i] <= 1'b0;
      end
    end
  end

`ifdef OPP_ARB_OVERRUN_EN
  logic [N_CH-1:0] r_overrun;

  // Sticky: a strobe landing on a still-pending word that is not being
  // granted this cycle means the older word is lost.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!chan_en_in[i])
          r_overrun[i] <= 1'b0;
        else if (data_valid_in[i] && r_pending[i] && !w_grant_vec[i])
          r_overrun[i] <= 1'b1;
      end
    end
  end

  assign overrun_out = r_overrun;
`endif

  // Issue FSM with registered outputs. busy follows the next state, so it is
  // high exactly while the registered state is ISSUE or DONE.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state      <= ST_IDLE;
      r_last_grant <= W_CH'(N_CH - 1);
      r_data       <= '0;
      r_chan       <= '0;
      r_req        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_data       <= r_word[w_grant_idx];
            r_chan       <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_req        <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Enable changes do not abort an issue; only the ack ends it.
          if (dac_if.dac_ack_in) begin
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_if.dac_data_out = r_data;
  assign dac_if.dac_chan_out = r_chan;
  assign dac_if.dac_req_out  = r_req;
  assign busy_out            = r_busy;

endmodule

// File: tb/tb_opp_dac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_opp_dac_arbiter
//   Self-checking bench for opp_dac_arbiter (N_CH=8, W_DATA=16, W_CH=3):
//   a vector table for the basic issue/priority sequences, hand-written
//   multi-cycle sequences (overwrite, stall, reset mid-issue), and a
//   randomized run compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_opp_dac_arbiter;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int WC = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    valid;
  logic [N-1:0]    en;
  logic            busy;
`ifdef OPP_ARB_OVERRUN_EN
  logic [N-1:0]    overrun;
`endif

  opp_dac_arbiter_if #(.W_DATA(W), .W_CH(WC)) dac_if ();

  opp_dac_arbiter #(.N_CH(N), .W_DATA(W), .W_CH(WC)) dut (
    .clk_in        (clk),
    .reset_n_in    (rst_n),
    .data_in       (data_in),
    .data_valid_in (valid),
    .chan_en_in    (en),
    .dac_if        (dac_if.master),
    .busy_out      (busy)
`ifdef OPP_ARB_OVERRUN_EN
    ,
    .overrun_out   (overrun)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a set of pending words, a round-robin pointer and a
  // "what the port is doing" phase (free / waiting for ack / gap cycle).
  // ---------------------------------------------------------------------------
  bit          m_pend [N];
  logic [W-1:0] m_word [N];
  bit [N-1:0]  m_ovr;
  int          m_last;
  int          m_phase;   // 0 free, 1 waiting for ack, 2 gap
  bit          m_req;
  int          m_chan;
  logic [W-1:0] m_data;

  task automatic model_step();
    int g;
    if (!rst_n) begin
      foreach (m_pend[c]) m_pend[c] = 0;
      m_ovr   = '0;
      m_last  = N - 1;
      m_phase = 0;
      m_req   = 0;
      m_chan  = 0;
      m_data  = '0;
      return;
    end
    g = -1;
    if (m_phase == 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g < 0 && m_pend[c] && en[c]) g = c;
      end
      if (g >= 0) begin
        m_chan  = g;
        m_data  = m_word[g];
        m_last  = g;
        m_req   = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (dac_if.dac_ack_in) begin
        m_req   = 0;
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    for (int c = 0; c < N; c++) begin
      if (!en[c]) begin
        m_pend[c] = 0;
        m_ovr[c]  = 0;
      end else if (valid[c]) begin
        if (m_pend[c] && c != g) m_ovr[c] = 1;
        m_word[c] = data_in[c*W +: W];
        m_pend[c] = 1;
      end else if (c == g) begin
        m_pend[c] = 0;
      end
    end
  endtask

  // One clock: inputs were driven before the edge, model follows the edge,
  // outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [63:0] dut_vec();
    logic [63:0] v;
    v = {40'd0, dac_if.dac_req_out, busy, 3'd0, dac_if.dac_chan_out, dac_if.dac_data_out};
`ifdef OPP_ARB_OVERRUN_EN
    v[63:56] = overrun;
`endif
    return v;
  endfunction

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    v = {40'd0, m_req, (m_phase != 0), 3'd0, 3'(m_chan), m_data};
`ifdef OPP_ARB_OVERRUN_EN
    v[63:56] = m_ovr;
`endif
    return v;
  endfunction

  function automatic logic [N*W-1:0] pattern(input logic [W-1:0] base);
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = base + W'(i);
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table: inputs for one edge and the outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst_n;
    logic [N-1:0] en;
    logic [N-1:0] valid;
    logic [W-1:0] dbase;    // ch i word = dbase + i
    logic         ack;
    logic         exp_req;
    logic [WC-1:0] exp_chan;
    logic [W-1:0] exp_data;
    logic         exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] e, input logic [N-1:0] v,
                              input logic [W-1:0] d, input logic a, input logic q,
                              input logic [WC-1:0] c, input logic [W-1:0] x, input logic b);
    vec_t t;
    t.rst_n = r; t.en = e; t.valid = v; t.dbase = d; t.ack = a;
    t.exp_req = q; t.exp_chan = c; t.exp_data = x; t.exp_busy = b;
    return t;
  endfunction

  vec_t tbl [27];

  initial begin
    int req_cnt;

    // Single word from ch2, ack held high: req one cycle, busy through DONE.
    tbl[0]  = mk(0, 8'hFF, 8'h00, 16'h0000, 1, 0, 0, 16'h0000, 0);
    tbl[1]  = mk(1, 8'hFF, 8'h04, 16'h1232, 1, 0, 0, 16'h0000, 0);
    tbl[2]  = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 1, 2, 16'h1234, 1);
    tbl[3]  = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 2, 16'h1234, 1);
    tbl[4]  = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 2, 16'h1234, 0);
    tbl[5]  = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 2, 16'h1234, 0);
    // Reset, then ch0/ch3/ch5 together: order 0,3,5 at one word per 3 cycles.
    tbl[6]  = mk(0, 8'hFF, 8'h00, 16'h0000, 1, 0, 0, 16'h0000, 0);
    tbl[7]  = mk(1, 8'hFF, 8'h29, 16'h5000, 1, 0, 0, 16'h0000, 0);
    tbl[8]  = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 1, 0, 16'h5000, 1);
    tbl[9]  = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 0, 16'h5000, 1);
    tbl[10] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 0, 16'h5000, 0);
    tbl[11] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 1, 3, 16'h5003, 1);
    tbl[12] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 3, 16'h5003, 1);
    tbl[13] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 3, 16'h5003, 0);
    tbl[14] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 1, 5, 16'h5005, 1);
    // ch0 and ch5 again: search from 5 wraps to 0 first.
    tbl[15] = mk(1, 8'hFF, 8'h21, 16'h6000, 1, 0, 5, 16'h5005, 1);
    tbl[16] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 5, 16'h5005, 0);
    tbl[17] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 1, 0, 16'h6000, 1);
    tbl[18] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 0, 16'h6000, 1);
    tbl[19] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 0, 16'h6000, 0);
    tbl[20] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 1, 5, 16'h6005, 1);
    tbl[21] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 5, 16'h6005, 1);
    tbl[22] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 5, 16'h6005, 0);
    tbl[23] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 5, 16'h6005, 0);
    // ch7 strobed while disabled, then enabled with no new strobe: no request.
    tbl[24] = mk(1, 8'h7F, 8'h80, 16'h7000, 1, 0, 5, 16'h6005, 0);
    tbl[25] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 5, 16'h6005, 0);
    tbl[26] = mk(1, 8'hFF, 8'h00, 16'h0000, 1, 0, 5, 16'h6005, 0);

    rst_n = 1'b0; en = '1; valid = '0; data_in = '0; dac_if.dac_ack_in = 1'b0;

    for (int i = 0; i < 27; i++) begin
      rst_n = tbl[i].rst_n;
      en = tbl[i].en;
      valid = tbl[i].valid;
      data_in = pattern(tbl[i].dbase);
      dac_if.dac_ack_in = tbl[i].ack;
      tick();
      check($sformatf("tbl[%0d]", i),
            {60'd0, dac_if.dac_req_out, busy, 2'd0} << 24 | {43'd0, dac_if.dac_chan_out, dac_if.dac_data_out},
            {60'd0, tbl[i].exp_req, tbl[i].exp_busy, 2'd0} << 24 | {43'd0, tbl[i].exp_chan, tbl[i].exp_data});
    end
    valid = '0;

    // ---- Overwrite before grant while ch4 holds the port -------------------
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    en = '1; dac_if.dac_ack_in = 1'b0;
    data_in = '0;
    valid = 8'h10; data_in[4*W +: W] = 16'h4444; tick();
    valid = '0; tick();
    check("ovw_ch4_issue", {dac_if.dac_req_out, dac_if.dac_chan_out, dac_if.dac_data_out},
          {1'b1, 3'd4, 16'h4444});
    valid = 8'h02; data_in[1*W +: W] = 16'h0001; tick();
    data_in[1*W +: W] = 16'h0002; tick();
    valid = '0; tick();
    check("ovw_ch4_held", {dac_if.dac_req_out, dac_if.dac_chan_out, dac_if.dac_data_out},
          {1'b1, 3'd4, 16'h4444});
`ifdef OPP_ARB_OVERRUN_EN
    check("ovw_overrun_set", {56'd0, overrun}, 64'h02);
`endif
    dac_if.dac_ack_in = 1'b1; tick();
    dac_if.dac_ack_in = 1'b0;
    check("ovw_ch4_acked", {63'd0, dac_if.dac_req_out}, 64'd0);
    tick(); tick();
    check("ovw_ch1_newest", {dac_if.dac_req_out, dac_if.dac_chan_out, dac_if.dac_data_out},
          {1'b1, 3'd1, 16'h0002});
    dac_if.dac_ack_in = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dac_if.dac_req_out) req_cnt++;
    end
    check("ovw_ch1_once", 64'(req_cnt), 64'd0);
`ifdef OPP_ARB_OVERRUN_EN
    check("ovw_overrun_sticky", {56'd0, overrun}, 64'h02);
`endif

    // ---- 20-cycle stall with ack low ---------------------------------------
    dac_if.dac_ack_in = 1'b0;
    valid = 8'h08; data_in[3*W +: W] = 16'hBEEF; tick();
    valid = '0; tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("stall[%0d]", i),
            {dac_if.dac_req_out, busy, dac_if.dac_chan_out, dac_if.dac_data_out},
            {1'b1, 1'b1, 3'd3, 16'hBEEF});
    end
    dac_if.dac_ack_in = 1'b1; tick();
    check("stall_release", {dac_if.dac_req_out, dac_if.dac_chan_out, dac_if.dac_data_out},
          {1'b0, 3'd3, 16'hBEEF});

    // ---- Reset during ISSUE with ch6 pending -------------------------------
    tick();
    dac_if.dac_ack_in = 1'b0;
    valid = 8'h04; data_in[2*W +: W] = 16'h2222; tick();
    valid = 8'h40; data_in[6*W +: W] = 16'h6666; tick();
    valid = '0;
    check("rst_mid_issue_pre", {dac_if.dac_req_out, dac_if.dac_chan_out, dac_if.dac_data_out},
          {1'b1, 3'd2, 16'h2222});
    rst_n = 1'b0; tick();
    check("rst_mid_issue_out", {busy, dac_if.dac_req_out, dac_if.dac_chan_out, dac_if.dac_data_out},
          {1'b0, 1'b0, 3'd0, 16'h0000});
    rst_n = 1'b1; dac_if.dac_ack_in = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dac_if.dac_req_out) req_cnt++;
    end
    check("rst_ch6_dropped", 64'(req_cnt), 64'd0);

    // ---- Randomized run against the model ----------------------------------
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en = ~(N'($urandom) & N'($urandom) & N'($urandom));
      valid = N'($urandom) & N'($urandom);
      for (int c = 0; c < N; c++) data_in[c*W +: W] = W'($urandom);
      dac_if.dac_ack_in = ($urandom_range(0, 2) != 0);
      tick();
      check($sformatf("rand[%0d]", i), dut_vec(), model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
